// File: rtl/enc_position.sv
// -----------------------------------------------------------------------------
// enc_position
//
// Position accumulator fed by the Pmod ENC decoder's direction levels. Each
// rising edge of the conditioned clockwise / counter-clockwise level is one
// detent. A detent moves a bounded position register by STEP. At the bounds
// the register wraps (WRAP=1) or saturates (WRAP=0). The register can also be
// cleared to RESET_VAL or loaded with a clamped value.
//
// Parameters:
//   WIDTH      position register width (2..16)
//   MIN_VAL    lower bound, inclusive
//   MAX_VAL    upper bound, inclusive (MIN_VAL < MAX_VAL < 2**WIDTH)
//   RESET_VAL  position after reset / clear, within [MIN_VAL, MAX_VAL]
//   STEP       change per detent (1 .. MAX_VAL-MIN_VAL)
//   WRAP       1: wrap at the bounds, 0: saturate at the bounds
//   SYNC_EN    1: two-flop synchroniser on dir0/dir1, 0: inputs used directly
//
// Ports:
//   clkSys     system clock
//   rst        asynchronous reset, active high
//   dir0       clockwise level from the decoder
//   dir1       counter-clockwise level from the decoder
//   clear      synchronous: position <= RESET_VAL
//   load       synchronous: position <= load_val, clamped (wins over clear)
//   load_val   value for load
//   position   current position (registered)
//   moved      one-cycle pulse: a detent changed the position
//   last_dir   direction of the last accepted detent (0 = CW, 1 = CCW)
//   wrapped    one-cycle pulse: a detent crossed a bound (wrapped or clipped)
//   at_max     position == MAX_VAL
//   at_min     position == MIN_VAL
// -----------------------------------------------------------------------------
module enc_position #(
    parameter int WIDTH     = 8,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 255,
    parameter int RESET_VAL = 0,
    parameter int STEP      = 1,
    parameter int WRAP      = 1,
    parameter int SYNC_EN   = 1
) (
    input  logic             clkSys,
    input  logic             rst,
    input  logic             dir0,
    input  logic             dir1,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] position,
    output logic             moved,
    output logic             last_dir,
    output logic             wrapped,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);
    // MAX_VAL+1 truncated to WIDTH bits; the wrap arithmetic is modular, so
    // the lost carry does not matter.
    localparam logic [WIDTH-1:0] MAXP1_W = WIDTH'(MAX_VAL + 1);
    localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);

    // -------------------------------------------------------------------------
    // Input conditioning
    // -------------------------------------------------------------------------
    logic cw_cond;
    logic ccw_cond;
    logic cond_vld;   // conditioned levels hold real samples, not reset values

    generate
        if (SYNC_EN != 0) begin : g_sync
            logic [1:0] cw_sync;
            logic [1:0] ccw_sync;
            logic [1:0] vld_sync;

            // NOTE: every flop here, the synchroniser included, is cleared by
            // the asynchronous reset so no stale level survives a reset.
            always_ff @(posedge clkSys or posedge rst) begin
                if (rst) begin
                    cw_sync  <= '0;
                    ccw_sync <= '0;
                    vld_sync <= '0;
                end else begin
                    cw_sync  <= {cw_sync[0], dir0};
                    ccw_sync <= {ccw_sync[0], dir1};
                    vld_sync <= {vld_sync[0], 1'b1};
                end
            end

            assign cw_cond  = cw_sync[1];
            assign ccw_cond = ccw_sync[1];
            assign cond_vld = vld_sync[1];
        end else begin : g_direct
            assign cw_cond  = dir0;
            assign ccw_cond = dir1;
            assign cond_vld = 1'b1;
        end
    endgenerate

    // Rising-edge detect. The arm flops only set once a genuine low level has
    // been seen after reset, so a level already high at reset release (or one
    // that just emerges from a reset-cleared synchroniser) is never counted.
    logic cw_dly;
    logic ccw_dly;
    logic cw_arm;
    logic ccw_arm;
    logic ev_cw;
    logic ev_ccw;

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clkSys or posedge rst) begin
        if (rst) begin
            cw_dly  <= 1'b0;
            ccw_dly <= 1'b0;
            cw_arm  <= 1'b0;
            ccw_arm <= 1'b0;
        end else begin
            cw_dly  <= cw_cond;
            ccw_dly <= ccw_cond;
            cw_arm  <= cw_arm  | (cond_vld & ~cw_cond);
            ccw_arm <= ccw_arm | (cond_vld & ~ccw_cond);
        end
    end

    assign ev_cw  = cw_cond  & ~cw_dly  & cw_arm;
    assign ev_ccw = ccw_cond & ~ccw_dly & ccw_arm;

    // -------------------------------------------------------------------------
    // Next-position arithmetic, one extra bit to expose carry / borrow
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   pos_x;
    logic [WIDTH:0]   sum_cw;
    logic [WIDTH:0]   diff_ccw;
    logic [WIDTH-1:0] sum_low;
    logic [WIDTH-1:0] diff_low;
    logic             cw_over;
    logic             ccw_under;
    logic [WIDTH-1:0] cw_next;
    logic [WIDTH-1:0] ccw_next;
    logic [WIDTH-1:0] load_clamped;

    // NOTE: every output of this block is assigned on every path, so no
    // latches are inferred.
    always_comb begin
        pos_x    = {1'b0, position};
        sum_cw   = pos_x + STEP_X;
        diff_ccw = pos_x - STEP_X;
        sum_low  = sum_cw[WIDTH-1:0];
        diff_low = diff_ccw[WIDTH-1:0];

        // Compared as signed ints so a zero MIN_VAL never degenerates into an
        // always-false unsigned compare.
        cw_over   = int'(sum_cw) > MAX_VAL;
        ccw_under = diff_ccw[WIDTH] || (int'(diff_low) < MIN_VAL);

        if (!cw_over) begin
            cw_next = sum_low;
        end else if (WRAP != 0) begin
            cw_next = sum_low - MAXP1_W + MIN_W;            // MIN + (s - MAX - 1)
        end else begin
            cw_next = MAX_W;
        end

        if (!ccw_under) begin
            ccw_next = diff_low;
        end else if (WRAP != 0) begin
            ccw_next = MAX_W - (MIN_W - diff_low - 1'b1);   // MAX - (MIN - s - 1)
        end else begin
            ccw_next = MIN_W;
        end

        if (int'(load_val) > MAX_VAL) begin
            load_clamped = MAX_W;
        end else if (int'(load_val) < MIN_VAL) begin
            load_clamped = MIN_W;
        end else begin
            load_clamped = load_val;
        end
    end

    // -------------------------------------------------------------------------
    // Position register and status pulses. Priority: load > clear > detent.
    // Opposing detents in the same cycle cancel completely.
    // -------------------------------------------------------------------------
    always_ff @(posedge clkSys or posedge rst) begin
        if (rst) begin
            position <= RESET_W;
            moved    <= 1'b0;
            wrapped  <= 1'b0;
            last_dir <= 1'b0;
        end else begin
            moved   <= 1'b0;
            wrapped <= 1'b0;
            if (load) begin
                position <= load_clamped;
            end else if (clear) begin
                position <= RESET_W;
            end else if (ev_cw && !ev_ccw) begin
                position <= cw_next;
                moved    <= (cw_next != position);
                wrapped  <= cw_over;
                last_dir <= 1'b0;
            end else if (ev_ccw && !ev_cw) begin
                position <= ccw_next;
                moved    <= (ccw_next != position);
                wrapped  <= ccw_under;
                last_dir <= 1'b1;
            end
        end
    end

    assign at_max = (position == MAX_W);
    assign at_min = (position == MIN_W);

endmodule

// File: doc/enc_position.md
# enc_position

Position accumulator that sits directly downstream of the Pmod ENC decoder. It consumes the decoder's clockwise (`dir0`) and counter-clockwise (`dir1`) detent indications and maintains a bounded position register. The register either wraps or saturates at its bounds and can be cleared or loaded. Its outputs drive displays, PWM setpoints or menu indices elsewhere in the design.

## Interface
Parameters:
- `WIDTH`, 8, width of the position register; 2..16.
- `MIN_VAL`, 0, lower bound, inclusive.
- `MAX_VAL`, 255, upper bound, inclusive; MIN_VAL < MAX_VAL < 2^WIDTH.
- `RESET_VAL`, 0, position after reset and after `clear`; must lie in [MIN_VAL, MAX_VAL].
- `STEP`, 1, increment per detent; 1 ≤ STEP ≤ MAX_VAL−MIN_VAL.
- `WRAP`, 1, 1: wrap at bounds; 0: saturate at bounds.
- `SYNC_EN`, 1, 1: 2-flop synchroniser on `dir0`/`dir1`; 0: inputs used directly.

Ports:
- `clkSys`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `dir0`  in  1  clockwise indication from the decoder; level, may stay high for many cycles.
- `dir1`  in  1  counter-clockwise indication from the decoder; same form as `dir0`.
- `clear`  in  1  synchronous: set position to RESET_VAL.
- `load`  in  1  synchronous: set position to `load_val`, clamped.
- `load_val`  in  WIDTH  value for `load`.
- `position`  out  WIDTH  current position, registered.
- `moved`  out  1  one-cycle pulse; position changed due to a detent.
- `last_dir`  out  1  direction of the last accepted detent; 0 = CW, 1 = CCW.
- `wrapped`  out  1  one-cycle pulse; a detent crossed a bound (wrapped, or clipped when saturating).
- `at_max`, `at_min`  out  1  each  `position == MAX_VAL` and `position == MIN_VAL`.

## Operation
- **Input conditioning**
  - If SYNC_EN=1, each direction input passes through two flops; otherwise it is used as-is.
  - A delay flop on the conditioned signal forms the rising-edge detect `ev_cw` / `ev_ccw`.
  - A level held high counts exactly once. The next count requires the conditioned input to go low for at least 1 cycle.
- **Priority per cycle:** `load` > `clear` > detent.
  - A detent arriving in the same cycle as `load` or `clear` is dropped; no `moved`, no `wrapped`.
- **Simultaneous detents:** `ev_cw` and `ev_ccw` in the same cycle cancel. No change and no pulses; `last_dir` is unchanged.
- **Arithmetic:** computed in WIDTH+1 bits so overflow and underflow are visible.
  - CW: `s = position + STEP`. If `s > MAX_VAL`:
    - WRAP=1: result `MIN_VAL + (s − MAX_VAL − 1)`.
    - WRAP=0: result `MAX_VAL`.
  - CCW: `s = position − STEP`. If `s < MIN_VAL` (including borrow):
    - WRAP=1: result `MAX_VAL − (MIN_VAL − s − 1)`.
    - WRAP=0: result `MIN_VAL`.
- **Status pulses and `last_dir`**
  - `wrapped` pulses whenever the bound branch is taken.
  - `moved` pulses only if the new position differs from the old. A saturating detent already at the bound gives `wrapped=1`, `moved=0`.
  - `last_dir` updates on every accepted detent, including clipped ones.
- **Load:** `load_val` above MAX_VAL loads MAX_VAL; below MIN_VAL loads MIN_VAL. `moved` and `wrapped` stay 0.
- **Reset:** asynchronous, and clears everything including the synchroniser and edge flops.
  - Reset values: `position`=RESET_VAL, `moved`=0, `wrapped`=0, `last_dir`=0. `at_max`/`at_min` follow from RESET_VAL.
  - An input already high when reset releases is not counted; the edge flops start low, and the input must fall and rise again.

## Timing
- Latency with SYNC_EN=1: `dir0` is first sampled high at edge k. `position`, `moved`, `wrapped` and `last_dir` update at edge k+2.
- Latency with SYNC_EN=0: update at the edge where `dir0` is first sampled high.
- `moved` and `wrapped` are high for exactly 1 cycle, aligned with the new `position`.
- `at_max` and `at_min` are decoded from the `position` register and are valid in the same cycle as `position`.
- Throughput: one detent per 2 cycles at most (high 1, low 1). Faster toggling below that rate is not required to count.
- `clear` and `load` take effect at the next edge, 1-cycle latency.

## Test plan
- **Reset:** assert `rst` mid-count with position=37 → `position`=0 immediately (asynchronous). `dir0` held high through release → no count until it toggles.
- **Single detent and hold:** defaults, `dir0` high for 50 cycles → position 0→1 exactly once. `moved` pulses once, 2 cycles after first sample; `last_dir`=0.
- **Wrap:** WRAP=1, STEP=5, position=253, one CW → position 2, `wrapped`=1. CCW from 2 → 253, `wrapped`=1.
- **Saturate:** WRAP=0, MIN_VAL=10, MAX_VAL=20, position=20, CW → stays 20, `wrapped`=1, `moved`=0, `at_max`=1. CCW → 19, `at_max`=0.
- **Simultaneous events:** `dir0` and `dir1` rise together → no change, no pulses. `load` with `load_val`=200 and a CW edge in the same cycle, MAX_VAL=150 → position 150, no `moved`.
- **Clear priority:** `load` and `clear` asserted together → load wins. `clear` alone → RESET_VAL.
